// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the scratch RAM.
// slave = arbiter side, master = requesters + RAM side.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 8
);
    logic                  h_req_i;
    logic                  h_we_i;
    logic [ADDR_WIDTH-1:0] h_addr_i;
    logic [DATA_WIDTH-1:0] h_wdata_i;
    logic                  h_ack_o;

    logic                  i_req_i;
    logic                  i_we_i;
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic [DATA_WIDTH-1:0] i_wdata_i;
    logic                  i_ack_o;

    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  ram_rd_o;
    logic                  ram_wr_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;
    logic                  busy_o;
    logic                  owner_o;
    logic [CNT_WIDTH-1:0]  conflict_cnt_o;
    logic [1:0]            state_o;

    // Handshake: req is a level held until the matching one-cycle ack;
    // we/addr/wdata must be stable while req is high.
    modport slave (
        input  h_req_i, h_we_i, h_addr_i, h_wdata_i,
        input  i_req_i, i_we_i, i_addr_i, i_wdata_i,
        input  ram_rdata_i,
        output h_ack_o, i_ack_o, rdata_o,
        output ram_rd_o, ram_wr_o, ram_addr_o, ram_wdata_o,
        output busy_o, owner_o, conflict_cnt_o, state_o
    );

    modport master (
        output h_req_i, h_we_i, h_addr_i, h_wdata_i,
        output i_req_i, i_we_i, i_addr_i, i_wdata_i,
        output ram_rdata_i,
        input  h_ack_o, i_ack_o, rdata_o,
        input  ram_rd_o, ram_wr_o, ram_addr_o, ram_wdata_o,
        input  busy_o, owner_o, conflict_cnt_o, state_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for the single-port debug scratch RAM.
// Define RAM_ARBITER_ROUND_ROBIN_EN to alternate grants on conflicts (default: fixed H priority).
module ram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 8
) (
    input logic         clk_i,
    input logic         reset_i,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, STROBE = 2'd1, CAPTURE = 2'd2, ACK = 2'd3} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                state_q, state_n;
    logic                  rd_q, rd_n;
    logic                  wr_q, wr_n;
    logic                  h_ack_q, h_ack_n;
    logic                  i_ack_q, i_ack_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
    logic                  owner_q, owner_n;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_n;
    logic                  we_q, we_n;
    logic                  granted_q, granted_n;
    logic                  busy_q, busy_n;
    logic                  conflict;
    logic                  grant_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            h_ack_q   <= 1'b0;
            i_ack_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            granted_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            rd_q      <= rd_n;
            wr_q      <= wr_n;
            h_ack_q   <= h_ack_n;
            i_ack_q   <= i_ack_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            rdata_q   <= rdata_n;
            owner_q   <= owner_n;
            cnt_q     <= cnt_n;
            we_q      <= we_n;
            granted_q <= granted_n;
            busy_q    <= busy_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        rd_n      = 1'b0;
        wr_n      = 1'b0;
        h_ack_n   = 1'b0;
        i_ack_n   = 1'b0;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        rdata_n   = rdata_q;
        owner_n   = owner_q;
        cnt_n     = cnt_q;
        we_n      = we_q;
        granted_n = granted_q;
        conflict  = 1'b0;
        grant_i   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.h_req_i || bus.i_req_i) begin
                    conflict = bus.h_req_i & bus.i_req_i;
                    if (conflict) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
                        // No grant yet since reset means H, even though ~owner_q would say I.
                        grant_i = granted_q & ~owner_q;
`else
                        grant_i = 1'b0;
`endif
                        if (cnt_q != '1) cnt_n = cnt_q + CNT_ONE;
                    end else begin
                        grant_i = bus.i_req_i;
                    end
                    owner_n   = grant_i;
                    granted_n = 1'b1;
                    we_n      = grant_i ? bus.i_we_i    : bus.h_we_i;
                    addr_n    = grant_i ? bus.i_addr_i  : bus.h_addr_i;
                    wdata_n   = grant_i ? bus.i_wdata_i : bus.h_wdata_i;
                    wr_n      = we_n;
                    rd_n      = ~we_n;
                    state_n   = STROBE;
                end
            end
            STROBE: state_n = CAPTURE;
            CAPTURE: begin
                // RAM data is valid this cycle, one cycle after the read strobe.
                if (!we_q) rdata_n = bus.ram_rdata_i;
                h_ack_n = ~owner_q;
                i_ack_n = owner_q;
                state_n = ACK;
            end
            ACK: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.ram_rd_o       = rd_q;
    assign bus.ram_wr_o       = wr_q;
    assign bus.ram_addr_o     = addr_q;
    assign bus.ram_wdata_o    = wdata_q;
    assign bus.h_ack_o        = h_ack_q;
    assign bus.i_ack_o        = i_ack_q;
    assign bus.rdata_o        = rdata_q;
    assign bus.busy_o         = busy_q;
    assign bus.owner_o        = owner_q;
    assign bus.conflict_cnt_o = cnt_q;
    assign bus.state_o        = state_q;
endmodule
